// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two core-side requesters, the arbiter and the shared memory port.
// Handshake: a requester raises reqN with addrN/wdataN/weN held stable until its one-cycle ackN;
// the arbiter holds mem_req high with stable mem_addr/mem_wdata/mem_we until a one-cycle mem_ack.
interface mem_port_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          req0;
    logic          req1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          we0;
    logic          we1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic          sel;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          err;
    logic          busy;

    // master: requesters plus memory model; slave: the arbiter
    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_ack, mem_rdata,
        input  ack0, ack1, rdata, sel, mem_req, mem_addr, mem_wdata, mem_we, err, busy
    );

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_ack, mem_rdata,
        output ack0, ack1, rdata, sel, mem_req, mem_addr, mem_wdata, mem_we, err, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (0) and load-store (1), one outstanding access.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN (aborts with err after TIMEOUT cycles).
module mem_port_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic          mem_req_q;
    logic          done;
    logic          abort;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be >= 2");
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;

    assign abort = (state_q == BUSY) && !bus.mem_ack && (cnt_q == CW'(TIMEOUT - 1));

    // Cleared whenever a transaction starts (grant from IDLE or hand-over on completion)
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE || done) cnt_d = '0;
        else                         cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign abort = 1'b0;
`endif

    assign done = (state_q == BUSY) && (bus.mem_ack || abort);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = BUSY;
                    sel_d   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                end
            end
            BUSY: begin
                if (done) begin
                    last_d = sel_q;
                    // The requester just served is not considered this cycle
                    if (sel_q ? bus.req0 : bus.req1) sel_d = ~sel_q;
                    else                             state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            mem_req_q <= (state_d == BUSY);
        end
    end

    assign addr_mux  = sel_q ? bus.addr1 : bus.addr0;
    assign wdata_mux = sel_q ? bus.wdata1 : bus.wdata0;

    assign bus.sel       = sel_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.mem_we    = (sel_q ? bus.we1 : bus.we0) & mem_req_q;
    assign bus.ack0      = done & ~sel_q;
    assign bus.ack1      = done & sel_q;
    assign bus.rdata     = (state_q == BUSY && bus.mem_ack) ? bus.mem_rdata : '0;
    assign bus.err       = abort;
    assign bus.busy      = (state_q == BUSY);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; timeout scenario follows ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.DW(32), .AW(32)) bus();

    mem_port_arbiter #(.DW(32), .AW(32), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.mem_ack = 0; bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk); #1;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0h exp=0", bus.mem_req); end
        total++; if (bus.sel !== 1'b0) begin bad++; $display("FAIL reset_sel got=%0h exp=0", bus.sel); end
        total++; if ({bus.ack0, bus.ack1, bus.err} !== 3'b000) begin bad++; $display("FAIL reset_acks got=%b exp=000", {bus.ack0, bus.ack1, bus.err}); end
        rst_n = 1'b1;
        // enter BUSY on requester 1 so reset must clear a non-zero sel
        @(negedge clk); bus.req1 = 1; bus.addr1 = 32'h44;
        @(negedge clk); #1;
        total++; if (bus.mem_req !== 1'b1 || bus.sel !== 1'b1) begin bad++; $display("FAIL busy_before_reset got=%0h%0h exp=11", bus.mem_req, bus.sel); end
        @(negedge clk);
        bus.mem_ack = 1; rst_n = 1'b0; #1;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL midbusy_reset_mem_req got=%0h exp=0", bus.mem_req); end
        total++; if ({bus.ack0, bus.ack1} !== 2'b00) begin bad++; $display("FAIL midbusy_reset_acks got=%b exp=00", {bus.ack0, bus.ack1}); end
        total++; if (bus.sel !== 1'b0) begin bad++; $display("FAIL midbusy_reset_sel got=%0h exp=0", bus.sel); end
        @(negedge clk); clear_inputs(); rst_n = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        total++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL post_reset_idle got=%0h%0h exp=00", bus.busy, bus.mem_req); end
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk);
        bus.req0 = 1; bus.addr0 = 32'h100; bus.we0 = 0; #1;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL read_req_latency got=%0h exp=0", bus.mem_req); end
        @(negedge clk); #1;
        total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL read_mem_req got=%0h exp=1", bus.mem_req); end
        total++; if (bus.mem_addr !== 32'h100) begin bad++; $display("FAIL read_addr got=%h exp=00000100", bus.mem_addr); end
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL read_we got=%0h exp=0", bus.mem_we); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            total++; if ({bus.ack0, bus.ack1} !== 2'b00) begin bad++; $display("FAIL read_early_ack got=%b exp=00", {bus.ack0, bus.ack1}); end
        end
        @(negedge clk);
        bus.mem_ack = 1; bus.mem_rdata = 32'hDEADBEEF; #1;
        total++; if ({bus.ack0, bus.ack1} !== 2'b10) begin bad++; $display("FAIL read_ack got=%b exp=10", {bus.ack0, bus.ack1}); end
        total++; if (bus.rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL read_rdata got=%h exp=deadbeef", bus.rdata); end
        @(negedge clk);
        bus.mem_ack = 0; bus.req0 = 0; #1;
        total++; if (bus.mem_req !== 1'b0 || bus.rdata !== 32'h0) begin bad++; $display("FAIL read_return_idle got=%0h/%h exp=0/0", bus.mem_req, bus.rdata); end
    endtask

    task automatic test_tie();
        do_reset();
        @(negedge clk);
        bus.req0 = 1; bus.req1 = 1; bus.addr0 = 32'h10; bus.addr1 = 32'h20;
        @(negedge clk); #1;
        total++; if (bus.sel !== 1'b0 || bus.mem_addr !== 32'h10) begin bad++; $display("FAIL tie_first got=%0h/%h exp=0/00000010", bus.sel, bus.mem_addr); end
        bus.mem_ack = 1; #1;
        total++; if ({bus.ack0, bus.ack1} !== 2'b10) begin bad++; $display("FAIL tie_ack0 got=%b exp=10", {bus.ack0, bus.ack1}); end
        @(negedge clk);
        bus.mem_ack = 0; bus.req0 = 0; #1;
        total++; if (bus.mem_req !== 1'b1 || bus.sel !== 1'b1 || bus.mem_addr !== 32'h20) begin bad++; $display("FAIL tie_b2b got=%0h%0h/%h exp=11/00000020", bus.mem_req, bus.sel, bus.mem_addr); end
        bus.mem_ack = 1; #1;
        total++; if ({bus.ack0, bus.ack1} !== 2'b01) begin bad++; $display("FAIL tie_ack1 got=%b exp=01", {bus.ack0, bus.ack1}); end
        @(negedge clk);
        bus.mem_ack = 0; bus.req1 = 0; #1;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL tie_end_idle got=%0h exp=0", bus.mem_req); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_ack;
        do_reset();
        @(negedge clk);
        bus.req0 = 1; bus.req1 = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.mem_ack = 0; #1;
            total++; if ({bus.ack0, bus.ack1} !== 2'b00 || bus.mem_req !== 1'b1) begin bad++; $display("FAIL fair_wait%0d got=%b/%0h exp=00/1", i, {bus.ack0, bus.ack1}, bus.mem_req); end
            @(negedge clk);
            bus.mem_ack = 1; #1;
            exp_ack = (i % 2 == 0) ? 2'b10 : 2'b01;
            total++; if ({bus.ack0, bus.ack1} !== exp_ack) begin bad++; $display("FAIL fair_ack%0d got=%b exp=%b", i, {bus.ack0, bus.ack1}, exp_ack); end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_write_steering();
        do_reset();
        @(negedge clk);
        bus.req1 = 1; bus.we1 = 1; bus.wdata1 = 32'hA5A5A5A5; bus.addr1 = 32'h200; #1;
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL write_we_idle got=%0h exp=0", bus.mem_we); end
        @(negedge clk); #1;
        total++; if (bus.mem_we !== 1'b1 || bus.sel !== 1'b1) begin bad++; $display("FAIL write_we_busy got=%0h%0h exp=11", bus.mem_we, bus.sel); end
        total++; if (bus.mem_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL write_wdata got=%h exp=a5a5a5a5", bus.mem_wdata); end
        bus.mem_ack = 1; #1;
        total++; if ({bus.ack0, bus.ack1} !== 2'b01) begin bad++; $display("FAIL write_ack got=%b exp=01", {bus.ack0, bus.ack1}); end
        @(negedge clk);
        bus.mem_ack = 0; bus.req1 = 0; bus.we1 = 1; #1;
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL write_we_after got=%0h exp=0", bus.mem_we); end
        // stray completion while idle
        @(negedge clk);
        bus.mem_ack = 1; bus.mem_rdata = 32'h12345678; #1;
        total++; if ({bus.ack0, bus.ack1} !== 2'b00 || bus.rdata !== 32'h0) begin bad++; $display("FAIL stray_ack got=%b/%h exp=00/0", {bus.ack0, bus.ack1}, bus.rdata); end
        @(negedge clk);
        bus.mem_ack = 0; #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stray_ack_state got=%0h exp=0", bus.busy); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        do_reset();
        @(negedge clk);
        bus.req0 = 1; bus.mem_rdata = 32'hCAFEF00D;
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk); #1;
            if (bus.ack0 || bus.ack1 || bus.err) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL timeout_early got=%0d exp=0", early); end
        @(negedge clk); #1;
        total++; if ({bus.ack0, bus.err} !== 2'b11) begin bad++; $display("FAIL timeout_abort got=%b exp=11", {bus.ack0, bus.err}); end
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL timeout_rdata got=%h exp=0", bus.rdata); end
        @(negedge clk);
        bus.req0 = 0; bus.mem_ack = 1; #1;
        total++; if ({bus.ack0, bus.ack1, bus.err, bus.mem_req} !== 4'b0000) begin bad++; $display("FAIL timeout_late_ack got=%b exp=0000", {bus.ack0, bus.ack1, bus.err, bus.mem_req}); end
`else
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk); #1;
            if (bus.ack0 || bus.ack1 || bus.err) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL nowatchdog_ack got=%0d exp=0", early); end
        total++; if (bus.busy !== 1'b1 || bus.mem_req !== 1'b1) begin bad++; $display("FAIL nowatchdog_busy got=%0h%0h exp=11", bus.busy, bus.mem_req); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL nowatchdog_err got=%0h exp=0", bus.err); end
`endif
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_read();
        test_tie();
        test_fairness();
        test_write_steering();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
